// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forwarding controller for the 5-stage MIPS pipeline.
// It tracks D-cache miss waits (RUN/DWAIT) and a busy counter for the
// multi-cycle mult/div unit. All outputs are combinational from state and inputs.
// Optional build macro HAZARD_PERF_CNT_EN adds stall_cycles_o / flush_count_o.
module hazard_ctrl #(
    parameter int  MD_LATENCY = 8,
    localparam int CNT_W      = $clog2(MD_LATENCY + 1)
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [4:0] rs_d_i,
    input  logic [4:0] rt_d_i,
    input  logic [4:0] rs_e_i,
    input  logic [4:0] rt_e_i,
    input  logic [4:0] write_reg_e_i,
    input  logic       reg_write_e_i,
    input  logic       mem_to_reg_e_i,
    input  logic [4:0] write_reg_m_i,
    input  logic       reg_write_m_i,
    input  logic       mem_to_reg_m_i,
    input  logic [4:0] write_reg_w_i,
    input  logic       reg_write_w_i,
    input  logic       branch_d_i,
    input  logic       pc_src_d_i,
    input  logic       md_start_e_i,
    input  logic       md_use_d_i,
    input  logic       imem_ready_i,
    input  logic       dmem_req_m_i,
    input  logic       dmem_ready_i,
    output logic       stall_f_o,
    output logic       stall_d_o,
    output logic       stall_e_o,
    output logic       stall_m_o,
    output logic       stall_w_o,
    output logic       flush_d_o,
    output logic       flush_e_o,
    output logic       fwd_a_d_o,
    output logic       fwd_b_d_o,
    output logic [1:0] fwd_a_e_o,
    output logic [1:0] fwd_b_e_o,
    output logic       md_busy_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles_o,
    output logic [31:0] flush_count_o
`endif
);

    typedef enum logic {RUN, DWAIT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

    logic freeze, lw_stall, br_stall, md_stall, i_stall, hazard;

    // Register $0 is hardwired to zero, so it never creates a dependency.
    function automatic logic hit(input logic [4:0] wr, input logic [4:0] src);
        return (wr != 5'd0) && (wr == src);
    endfunction

    // Hazard detection terms
    always_comb begin
        freeze   = dmem_req_m_i & ~dmem_ready_i;
        lw_stall = mem_to_reg_e_i & (hit(write_reg_e_i, rs_d_i) | hit(write_reg_e_i, rt_d_i));
        br_stall = branch_d_i &
                   ((reg_write_e_i  & (hit(write_reg_e_i, rs_d_i) | hit(write_reg_e_i, rt_d_i))) |
                    (mem_to_reg_m_i & (hit(write_reg_m_i, rs_d_i) | hit(write_reg_m_i, rt_d_i))));
        md_stall = md_use_d_i & (md_cnt_q != '0);
        i_stall  = ~imem_ready_i;
        hazard   = lw_stall | br_stall | md_stall | i_stall;
    end

    // Output decode: reset forces everything low; a cache freeze overrides hazards
    always_comb begin
        stall_f_o = 1'b0;
        stall_d_o = 1'b0;
        stall_e_o = 1'b0;
        stall_m_o = 1'b0;
        stall_w_o = 1'b0;
        flush_d_o = 1'b0;
        flush_e_o = 1'b0;
        fwd_a_d_o = 1'b0;
        fwd_b_d_o = 1'b0;
        fwd_a_e_o = 2'b00;
        fwd_b_e_o = 2'b00;
        md_busy_o = 1'b0;
        if (!rst_i) begin
            fwd_a_d_o = reg_write_m_i & hit(write_reg_m_i, rs_d_i);
            fwd_b_d_o = reg_write_m_i & hit(write_reg_m_i, rt_d_i);
            if (reg_write_m_i & hit(write_reg_m_i, rs_e_i))      fwd_a_e_o = 2'b10;
            else if (reg_write_w_i & hit(write_reg_w_i, rs_e_i)) fwd_a_e_o = 2'b01;
            if (reg_write_m_i & hit(write_reg_m_i, rt_e_i))      fwd_b_e_o = 2'b10;
            else if (reg_write_w_i & hit(write_reg_w_i, rt_e_i)) fwd_b_e_o = 2'b01;
            md_busy_o = (md_cnt_q != '0);
            if (freeze) begin
                stall_f_o = 1'b1;
                stall_d_o = 1'b1;
                stall_e_o = 1'b1;
                stall_m_o = 1'b1;
                stall_w_o = 1'b1;
            end else if (hazard) begin
                stall_f_o = 1'b1;
                stall_d_o = 1'b1;
                flush_e_o = 1'b1;
            end
            // A stalled redirect is simply retried once the hazard clears.
            flush_d_o = pc_src_d_i & ~stall_d_o & ~freeze;
        end
    end

    // Next state for the D-cache wait FSM and the mult/div busy counter
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        case (state_q)
            RUN:     if (freeze)       state_d = DWAIT;
            DWAIT:   if (dmem_ready_i) state_d = RUN;
            default: state_d = RUN;
        endcase
        // An issue during a freeze is held in E and re-issued later, so ignore it.
        if (md_start_e_i & ~freeze) md_cnt_d = CNT_W'(MD_LATENCY);
        else if (md_cnt_q != '0)    md_cnt_d = md_cnt_q - 1'b1;
    end

    // State and counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= RUN;
            md_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_count_q, flush_count_d;

    // Free-running event counters, wrapping at 2^32
    always_comb begin
        stall_cycles_d = stall_cycles_q + 32'(stall_f_o);
        flush_count_d  = flush_count_q + 32'(flush_d_o | flush_e_o);
    end

    // Performance counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign flush_count_o  = flush_count_q;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: each step drives inputs, pushes the expected
// output word to a scoreboard queue, then pops and checks it mid-cycle.
module tb_hazard_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [4:0] rs_d_i, rt_d_i, rs_e_i, rt_e_i;
    logic [4:0] write_reg_e_i, write_reg_m_i, write_reg_w_i;
    logic       reg_write_e_i, mem_to_reg_e_i, reg_write_m_i, mem_to_reg_m_i, reg_write_w_i;
    logic       branch_d_i, pc_src_d_i, md_start_e_i, md_use_d_i;
    logic       imem_ready_i, dmem_req_m_i, dmem_ready_i;
    logic       stall_f_o, stall_d_o, stall_e_o, stall_m_o, stall_w_o;
    logic       flush_d_o, flush_e_o, fwd_a_d_o, fwd_b_d_o, md_busy_o;
    logic [1:0] fwd_a_e_o, fwd_b_e_o;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_o, flush_count_o;
    logic [31:0] m_stall, m_flush;
    bit          perf_ok = 0;
`endif

    hazard_ctrl #(.MD_LATENCY(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .rs_d_i(rs_d_i), .rt_d_i(rt_d_i), .rs_e_i(rs_e_i), .rt_e_i(rt_e_i),
        .write_reg_e_i(write_reg_e_i), .reg_write_e_i(reg_write_e_i), .mem_to_reg_e_i(mem_to_reg_e_i),
        .write_reg_m_i(write_reg_m_i), .reg_write_m_i(reg_write_m_i), .mem_to_reg_m_i(mem_to_reg_m_i),
        .write_reg_w_i(write_reg_w_i), .reg_write_w_i(reg_write_w_i),
        .branch_d_i(branch_d_i), .pc_src_d_i(pc_src_d_i),
        .md_start_e_i(md_start_e_i), .md_use_d_i(md_use_d_i),
        .imem_ready_i(imem_ready_i), .dmem_req_m_i(dmem_req_m_i), .dmem_ready_i(dmem_ready_i),
        .stall_f_o(stall_f_o), .stall_d_o(stall_d_o), .stall_e_o(stall_e_o),
        .stall_m_o(stall_m_o), .stall_w_o(stall_w_o),
        .flush_d_o(flush_d_o), .flush_e_o(flush_e_o),
        .fwd_a_d_o(fwd_a_d_o), .fwd_b_d_o(fwd_b_d_o),
        .fwd_a_e_o(fwd_a_e_o), .fwd_b_e_o(fwd_b_e_o),
        .md_busy_o(md_busy_o)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles_o(stall_cycles_o), .flush_count_o(flush_count_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Output word: {sf,sd,se,sm,sw,fd,fe,fad,fbd,fae[1:0],fbe[1:0],busy}
    logic [13:0] obs;
    assign obs = {stall_f_o, stall_d_o, stall_e_o, stall_m_o, stall_w_o, flush_d_o, flush_e_o,
                  fwd_a_d_o, fwd_b_d_o, fwd_a_e_o, fwd_b_e_o, md_busy_o};

    localparam logic [13:0] Z     = 14'h0000;
    localparam logic [13:0] HZ    = 14'h3080;  // stall_f, stall_d, flush_e
    localparam logic [13:0] FRZ   = 14'h3E00;  // all five stalls
    localparam logic [13:0] FD    = 14'h0100;
    localparam logic [13:0] FAD   = 14'h0040;
    localparam logic [13:0] FBD   = 14'h0020;
    localparam logic [13:0] FAE_M = 14'h0010;
    localparam logic [13:0] FBE_M = 14'h0004;
    localparam logic [13:0] FBE_W = 14'h0002;
    localparam logic [13:0] BUSY  = 14'h0001;

    logic [13:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic clr();
        rst_i = 0;
        rs_d_i = 0; rt_d_i = 0; rs_e_i = 0; rt_e_i = 0;
        write_reg_e_i = 0; write_reg_m_i = 0; write_reg_w_i = 0;
        reg_write_e_i = 0; mem_to_reg_e_i = 0; reg_write_m_i = 0; mem_to_reg_m_i = 0; reg_write_w_i = 0;
        branch_d_i = 0; pc_src_d_i = 0; md_start_e_i = 0; md_use_d_i = 0;
        imem_ready_i = 1; dmem_req_m_i = 0; dmem_ready_i = 1;
    endtask

    // Inputs are already driven; push expectation, compare mid-cycle, advance one clock.
    task automatic step(input string tag, input logic [13:0] want);
        logic [13:0] e;
        exp_q.push_back(want);
        #3;
        if (exp_q.size() == 0) begin
            total++; bad++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            check(tag, 32'(obs), 32'(e));
        end
`ifdef HAZARD_PERF_CNT_EN
        if (perf_ok) begin
            check({tag, "_stallcnt"}, stall_cycles_o, m_stall);
            check({tag, "_flushcnt"}, flush_count_o, m_flush);
        end
        if (rst_i) begin
            m_stall = 0; m_flush = 0; perf_ok = 1;
        end else begin
            m_stall = m_stall + 32'(want[13]);
            m_flush = m_flush + 32'(want[8] | want[7]);
        end
`endif
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // Reset with hazards and a miss on the inputs: outputs forced low
        clr(); rst_i = 1; mem_to_reg_e_i = 1; write_reg_e_i = 8; rs_d_i = 8;
        dmem_req_m_i = 1; dmem_ready_i = 0; imem_ready_i = 0;
        step("reset0", Z);
        step("reset1", Z);
        clr(); step("idle", Z);

        // Load-use stall, then M->E forward next cycle
        clr(); mem_to_reg_e_i = 1; reg_write_e_i = 1; write_reg_e_i = 8; rs_d_i = 8;
        step("lw_stall", HZ);
        clr(); reg_write_m_i = 1; write_reg_m_i = 8; rs_e_i = 8;
        step("fwd_m_e", FAE_M);
        clr(); reg_write_w_i = 1; write_reg_w_i = 9; rt_e_i = 9;
        step("fwd_w_e", FBE_W);
        clr(); reg_write_m_i = 1; write_reg_m_i = 9; reg_write_w_i = 1; write_reg_w_i = 9; rt_e_i = 9;
        step("fwd_m_prio", FBE_M);
        clr(); reg_write_m_i = 1; write_reg_m_i = 4; rs_d_i = 4; rt_d_i = 4;
        step("fwd_d", FAD | FBD);

        // $0 never forwards or stalls
        clr(); reg_write_m_i = 1; write_reg_m_i = 0; reg_write_w_i = 1; write_reg_w_i = 0;
        mem_to_reg_e_i = 1; write_reg_e_i = 0; rs_e_i = 0; rt_e_i = 0; rs_d_i = 0;
        step("reg0", Z);

        // Branch hazards and I-cache miss
        clr(); branch_d_i = 1; reg_write_e_i = 1; write_reg_e_i = 3; rt_d_i = 3;
        step("br_e", HZ);
        clr(); branch_d_i = 1; mem_to_reg_m_i = 1; reg_write_m_i = 1; write_reg_m_i = 5; rs_d_i = 5;
        step("br_m", HZ | FAD);
        clr(); imem_ready_i = 0;
        step("i_stall", HZ);

        // Redirect flush, and hazard priority over redirect
        clr(); pc_src_d_i = 1;
        step("redirect", FD);
        clr(); pc_src_d_i = 1; mem_to_reg_e_i = 1; write_reg_e_i = 7; rt_d_i = 7;
        step("redirect_lw", HZ);

        // Mult/div: issue at t0, use stalls t1..t8, release t9
        clr(); md_start_e_i = 1;
        step("md_issue", Z);
        for (int i = 1; i <= 8; i++) begin
            clr(); md_use_d_i = 1;
            step($sformatf("md_use_t%0d", i), HZ | BUSY);
        end
        clr(); md_use_d_i = 1;
        step("md_release", Z);

        // D-cache freeze for 5 cycles, counter keeps running, redirect/hazard suppressed
        clr(); md_start_e_i = 1;
        step("frz_issue", Z);
        for (int i = 1; i <= 5; i++) begin
            clr(); dmem_req_m_i = 1; dmem_ready_i = 0; pc_src_d_i = 1;
            mem_to_reg_e_i = 1; write_reg_e_i = 6; rs_d_i = 6;
            step($sformatf("freeze_t%0d", i), FRZ | BUSY);
        end
        clr(); dmem_req_m_i = 1; dmem_ready_i = 1;
        step("frz_release", BUSY);
        clr(); step("frz_cnt2", BUSY);
        clr(); step("frz_cnt1", BUSY);
        clr(); step("frz_cnt0", Z);

        // Issue during a freeze must not load the counter
        clr(); md_start_e_i = 1; dmem_req_m_i = 1; dmem_ready_i = 0;
        step("frz_no_issue", FRZ);
        clr(); step("frz_no_issue_after", Z);

        // Reset in DWAIT with counter at 5
        clr(); md_start_e_i = 1;
        step("rst_issue", Z);
        for (int i = 1; i <= 3; i++) begin
            clr(); dmem_req_m_i = 1; dmem_ready_i = 0;
            step($sformatf("rst_frz_t%0d", i), FRZ | BUSY);
        end
        clr(); dmem_req_m_i = 1; dmem_ready_i = 0; md_use_d_i = 1; rst_i = 1;
        step("rst_in_dwait", Z);
        clr(); md_use_d_i = 1;
        step("after_rst", Z);
        clr(); step("after_rst_idle", Z);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
